dm_arbiter: RTL and testbench

- Shares the single-ported, word-organised data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader).
- Provides round-robin arbitration, a registered read-return path, and read-modify-write sequencing for byte/halfword stores, because the memory writes whole words only.
- Sits between the requesters and the data memory; drives the memory's read address, write address, write data and write enable.

---
 rtl/dm_arbiter.sv | 133 +++++++++++++
 tb/tb_dm_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter for a word-wide data memory: round-robin grants, registered read return,
// and read-modify-write for partial stores. Define DM_ARB_PRIO0_EN for fixed port-0 priority.
`timescale 1ns/1ps
module dm_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    input  logic [3:0]            be0,
    input  logic [3:0]            be1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata0,
    output logic [31:0]           rdata1,
    output logic [ADDR_WIDTH-1:0] dm_read_addr,
    output logic [ADDR_WIDTH-1:0] dm_write_addr,
    output logic [31:0]           dm_write_data,
    output logic                  dm_write_enable,
    input  logic [31:0]           dm_read_result
);
    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_RMW_WRITE = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    logic [0:0]            state_q, state_d;
    logic [31:0]           merge_q, merge_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [31:0]           rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                  pick1;
    logic                  grant_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_waddr;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_be;
    logic [31:0]           mask;

`ifdef DM_ARB_PRIO0_EN
    always_comb pick1 = req1 && !req0;
`else
    logic rr_q, rr_d;

    // Pointer names the port that wins the next simultaneous request.
    always_comb begin
        pick1 = req1 && (!req0 || rr_q);
        rr_d  = rr_q;
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        grant_any       = (state_q == S_IDLE) && (req0 || req1) && !reset;
        gnt0            = grant_any && !pick1;
        gnt1            = grant_any && pick1;
        sel_we          = pick1 ? we1 : we0;
        sel_waddr       = (pick1 ? addr1 : addr0) & WORD_MASK;
        sel_wdata       = pick1 ? wdata1 : wdata0;
        sel_be          = pick1 ? be1 : be0;
        mask            = {{8{sel_be[3]}}, {8{sel_be[2]}}, {8{sel_be[1]}}, {8{sel_be[0]}}};

        state_d         = S_IDLE;
        merge_d         = merge_q;
        waddr_d         = waddr_q;
        rvalid0_d       = gnt0 && !sel_we;
        rvalid1_d       = gnt1 && !sel_we;
        rdata0_d        = rvalid0_d ? dm_read_result : rdata0_q;
        rdata1_d        = rvalid1_d ? dm_read_result : rdata1_q;

        dm_read_addr    = sel_waddr;
        dm_write_addr   = sel_waddr;
        dm_write_data   = sel_wdata;
        dm_write_enable = 1'b0;

        if (state_q == S_RMW_WRITE) begin
            dm_write_addr   = waddr_q;
            dm_write_data   = merge_q;
            dm_write_enable = !reset;
        end else if (grant_any && sel_we) begin
            if (sel_be == 4'b1111) begin
                dm_write_enable = 1'b1;
            end else if (sel_be != 4'b0000) begin
                // The read lane of this cycle supplies the bytes the store leaves untouched.
                merge_d = (dm_read_result & ~mask) | (sel_wdata & mask);
                waddr_d = sel_waddr;
                state_d = S_RMW_WRITE;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            merge_q   <= '0;
            waddr_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            merge_q   <= merge_d;
            waddr_q   <= waddr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: behavioural word memory, queued read expectations
// checked by a negedge monitor, directed arbitration / RMW / reset scenarios.
`timescale 1ns/1ps
module tb_dm_arbiter;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic [3:0]    be0 = '0, be1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] dm_read_addr, dm_write_addr;
    logic [31:0]   dm_write_data, dm_read_result;
    logic          dm_write_enable;

    logic [31:0]   mem [0:1023];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic          we_log [0:4095];
    int            gnt_log [$];
    logic [31:0]   q0 [$];
    logic [31:0]   q1 [$];
    logic          pend0 = 1'b0, pend1 = 1'b0;

`ifdef DM_ARB_PRIO0_EN
    int exp_seq [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    int exp_seq [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

    dm_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
        .dm_write_data(dm_write_data), .dm_write_enable(dm_write_enable),
        .dm_read_result(dm_read_result)
    );

    always #5 clk = ~clk;

    assign dm_read_result = mem[dm_read_addr[AW-1:2]];

    always @(posedge clk) begin
        if (dm_write_enable) mem[dm_write_addr[AW-1:2]] <= dm_write_data;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: read-return timing and data, grant order, write-enable history.
    always @(negedge clk) begin
        we_log[cyc % 4096] <= dm_write_enable;
        if (!reset && gnt0) gnt_log.push_back(0);
        if (!reset && gnt1) gnt_log.push_back(1);
        if (gnt0 && gnt1) check("gnt_onehot", {30'd0, gnt1, gnt0}, 32'd1);
        if (rvalid0 || (pend0 && !reset)) check("rvalid0_timing", {31'd0, rvalid0}, {31'd0, pend0 && !reset});
        if (rvalid1 || (pend1 && !reset)) check("rvalid1_timing", {31'd0, rvalid1}, {31'd0, pend1 && !reset});
        if (rvalid0 && q0.size() != 0) check("rdata0", rdata0, q0.pop_front());
        if (rvalid1 && q1.size() != 0) check("rdata1", rdata1, q1.pop_front());
        pend0 <= !reset && gnt0 && !we0;
        pend1 <= !reset && gnt1 && !we1;
    end

    // Called just after a rising edge; returns just after the edge ending the grant cycle,
    // leaving the request asserted so the caller may chain another access back-to-back.
    task automatic drive(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int gc);
        logic got;
        got = 1'b0;
        gc  = 0;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; be0 = be; end
        else        begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; be1 = be; end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin
                got = 1'b1;
                gc  = cyc;
            end
        end
        check((p == 0) ? "gnt0_seen" : "gnt1_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic release_port(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin
        int g, ga, gb, base;

        // Reset: a pending request must not be granted while reset is high.
        req0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_we", {31'd0, dm_write_enable}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        req0  = 1'b0;
        reset = 1'b0;

        // Preload words through port 0 full writes.
        drive(0, 1'b1, 12'h020, 32'h11223344, 4'hF, g);
        drive(0, 1'b1, 12'h030, 32'hAABBCCDD, 4'hF, g);
        drive(0, 1'b1, 12'h040, 32'h00000000, 4'hF, g);
        drive(0, 1'b1, 12'h050, 32'h12345678, 4'hF, g);

        // Full write then back-to-back read on port 0.
        drive(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, ga);
        q0.push_back(32'hDEADBEEF);
        drive(0, 1'b0, 12'h010, 32'h0, 4'h0, gb);
        release_port(0);
        check("full_write_we", {31'd0, we_log[ga % 4096]}, 32'd1);
        check("read_regrant_next", gb, ga + 1);

        // Partial write by port 1: RMW over two cycles.
        drive(1, 1'b1, 12'h020, 32'h0000AA00, 4'b0010, g);
        release_port(1);
        @(posedge clk);
        #1;
        check("rmw_we_T", {31'd0, we_log[g % 4096]}, 32'd0);
        check("rmw_we_T1", {31'd0, we_log[(g + 1) % 4096]}, 32'd1);
        check("rmw_word_020", mem[12'h020 >> 2], 32'h1122AA44);

        // Both ports request four reads each.
        base = gnt_log.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back((i % 2 == 0) ? 32'hDEADBEEF : 32'h1122AA44);
            q1.push_back((i % 2 == 0) ? 32'h1122AA44 : 32'hDEADBEEF);
        end
        fork
            begin
                int gx;
                for (int i = 0; i < 4; i++) drive(0, 1'b0, (i % 2 == 0) ? 12'h010 : 12'h020, 32'h0, 4'h0, gx);
                release_port(0);
            end
            begin
                int gy;
                for (int i = 0; i < 4; i++) drive(1, 1'b0, (i % 2 == 0) ? 12'h020 : 12'h010, 32'h0, 4'h0, gy);
                release_port(1);
            end
        join
        check("grant_count", gnt_log.size() - base, 32'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < gnt_log.size()) check("grant_order", gnt_log[base + i], exp_seq[i]);
        repeat (2) @(posedge clk);
        #1;

        // Partial write on port 0 while port 1 reads the same word.
        q1.push_back(32'h1234CCDD);
        fork
            begin
                drive(0, 1'b1, 12'h030, 32'h12340000, 4'b1100, ga);
                release_port(0);
            end
            begin
                drive(1, 1'b0, 12'h030, 32'h0, 4'h0, gb);
                release_port(1);
            end
        join
        check("rmw_read_gnt1_T2", gb, ga + 2);
        repeat (2) @(posedge clk);
        #1;
        check("rmw_word_030", mem[12'h030 >> 2], 32'h1234CCDD);

        // Reset asserted in the RMW_WRITE cycle drops the pending write.
        drive(0, 1'b1, 12'h041, 32'h000000FF, 4'b0001, g);
        release_port(0);
        reset = 1'b1;
        @(negedge clk);
        check("rmw_rst_we", {31'd0, dm_write_enable}, 32'd0);
        check("rmw_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rmw_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rmw_rst_word_040", mem[12'h040 >> 2], 32'h00000000);

        // Zero byte-enable write: grant only.
        drive(1, 1'b1, 12'h050, 32'h0000FFFF, 4'b0000, g);
        release_port(1);
        @(posedge clk);
        #1;
        check("be0_we_T", {31'd0, we_log[g % 4096]}, 32'd0);
        check("be0_we_T1", {31'd0, we_log[(g + 1) % 4096]}, 32'd0);
        check("be0_word_050", mem[12'h050 >> 2], 32'h12345678);

        // Idle: memory addresses follow port 0, word aligned.
        addr0 = 12'h013;
        @(negedge clk);
        check("idle_read_addr", {20'd0, dm_read_addr}, 32'h010);
        check("idle_write_addr", {20'd0, dm_write_addr}, 32'h010);
        check("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        repeat (3) @(posedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end
endmodule
